// File: rtl/game_pkg.sv
// Shared types for the collision query path.
//   CW      : coordinate/size width in screen units
//   state_t : scanner FSM states
//   box_t   : axis-aligned box {x, y, w, h}; (x, y) is the top-left corner
package game_pkg;

  localparam int unsigned CW = 9;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [CW-1:0] w;
    logic [CW-1:0] h;
  } box_t;

endpackage

// File: rtl/aabb_overlap.sv
// Combinational strict AABB overlap test between box A and box B.
// Edges that only touch do not count, and a box with zero width or zero height
// never overlaps anything. Far edges are formed at CW+1 bits so boxes near the
// right or bottom of the screen do not wrap.
//   a_x_i, a_y_i, a_w_i, a_h_i : box A (top-left, width, height)
//   b_x_i, b_y_i, b_w_i, b_h_i : box B
//   overlap_o                  : 1 when the interiors intersect
module aabb_overlap #(
  parameter int unsigned CW = 9
) (
  input  logic [CW-1:0] a_x_i,
  input  logic [CW-1:0] a_y_i,
  input  logic [CW-1:0] a_w_i,
  input  logic [CW-1:0] a_h_i,
  input  logic [CW-1:0] b_x_i,
  input  logic [CW-1:0] b_y_i,
  input  logic [CW-1:0] b_w_i,
  input  logic [CW-1:0] b_h_i,
  output logic          overlap_o
);

  logic [CW:0] a_xe, a_ye, b_xe, b_ye;
  logic        nonempty;

  assign a_xe = {1'b0, a_x_i} + {1'b0, a_w_i};
  assign a_ye = {1'b0, a_y_i} + {1'b0, a_h_i};
  assign b_xe = {1'b0, b_x_i} + {1'b0, b_w_i};
  assign b_ye = {1'b0, b_y_i} + {1'b0, b_h_i};

  // Without this guard a zero-width box strictly inside the other span would hit.
  assign nonempty = (|a_w_i) & (|a_h_i) & (|b_w_i) & (|b_h_i);

  assign overlap_o = nonempty
                   & ({1'b0, a_x_i} < b_xe) & (a_xe > {1'b0, b_x_i})
                   & ({1'b0, a_y_i} < b_ye) & (a_ye > {1'b0, b_y_i});

endmodule

// File: rtl/collide_scanner.sv
// AABB collision query initiator. A start pulse in IDLE latches the probe box,
// then the object table is read once per cycle over a 1-cycle sync-read port
// and every enabled entry is tested against the probe.
//   clk, rst_n               : clock, asynchronous active-low reset
//   start                    : request pulse, accepted only in IDLE
//   px, py, pw, ph           : probe box, latched on accepted start
//   obj_addr, obj_rd         : table read address / strobe
//   obj_en, ox, oy, ow, oh   : table entry, valid the cycle after obj_rd
//   busy                     : scan in progress (FETCH and DRAIN)
//   done                     : 1-cycle pulse, results valid from this cycle on
//   hit_mask, hit_any, hit_idx : per-entry hits, any hit, lowest hit index
module collide_scanner
  import game_pkg::*;
#(
  parameter int unsigned N_OBJ = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned CW    = game_pkg::CW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CW-1:0]    px,
  input  logic [CW-1:0]    py,
  input  logic [CW-1:0]    pw,
  input  logic [CW-1:0]    ph,
  output logic [AW-1:0]    obj_addr,
  output logic             obj_rd,
  input  logic             obj_en,
  input  logic [CW-1:0]    ox,
  input  logic [CW-1:0]    oy,
  input  logic [CW-1:0]    ow,
  input  logic [CW-1:0]    oh,
  output logic             busy,
  output logic             done,
  output logic [N_OBJ-1:0] hit_mask,
  output logic             hit_any,
  output logic [AW-1:0]    hit_idx
);

  localparam logic [AW-1:0] LAST = AW'(N_OBJ - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            rd_vld_q;
  logic [AW-1:0]   rd_idx_q;
  logic [CW-1:0]   px_q, py_q, pw_q, ph_q;
  logic [N_OBJ-1:0] hit_mask_q, hit_mask_d;
  logic            hit_any_q, hit_any_d;
  logic [AW-1:0]   hit_idx_q, hit_idx_d;
  logic            accept;
  logic            overlap;
  logic            entry_hit;

  aabb_overlap #(.CW(CW)) u_overlap (
    .a_x_i     (px_q),
    .a_y_i     (py_q),
    .a_w_i     (pw_q),
    .a_h_i     (ph_q),
    .b_x_i     (ox),
    .b_y_i     (oy),
    .b_w_i     (ow),
    .b_h_i     (oh),
    .overlap_o (overlap)
  );

  // Table data is only meaningful on the cycle after a read; gating here keeps
  // unknown entry values out of the result registers.
  assign entry_hit = rd_vld_q & obj_en & overlap;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    accept  = 1'b0;
    obj_rd  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          addr_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        obj_rd = 1'b1;
        busy   = 1'b1;
        if (addr_q == LAST) begin
          addr_d  = '0;
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ascending scan order means the first hit seen is the lowest index.
  always_comb begin
    hit_mask_d = hit_mask_q;
    hit_any_d  = hit_any_q;
    hit_idx_d  = hit_idx_q;
    if (accept) begin
      hit_mask_d = '0;
      hit_any_d  = 1'b0;
      hit_idx_d  = '0;
    end else if (entry_hit) begin
      hit_mask_d[rd_idx_q] = 1'b1;
      if (!hit_any_q) begin
        hit_any_d = 1'b1;
        hit_idx_d = rd_idx_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rd_vld_q   <= 1'b0;
      rd_idx_q   <= '0;
      px_q       <= '0;
      py_q       <= '0;
      pw_q       <= '0;
      ph_q       <= '0;
      hit_mask_q <= '0;
      hit_any_q  <= 1'b0;
      hit_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_vld_q   <= obj_rd;
      rd_idx_q   <= addr_q;
      hit_mask_q <= hit_mask_d;
      hit_any_q  <= hit_any_d;
      hit_idx_q  <= hit_idx_d;
      if (accept) begin
        px_q <= px;
        py_q <= py;
        pw_q <= pw;
        ph_q <= ph;
      end
    end
  end

  assign obj_addr = addr_q;
  assign hit_mask = hit_mask_q;
  assign hit_any  = hit_any_q;
  assign hit_idx  = hit_idx_q;

endmodule

// File: tb/tb_collide_scanner.sv
// Self-checking bench for collide_scanner: directed vector table, hand-written
// corner sequences (reset mid-scan, ignored starts, back-to-back scans) and
// randomized scans checked against a behavioural model of the overlap rules.
module tb_collide_scanner;
  import game_pkg::*;

  localparam int N  = 16;
  localparam int AWD = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [8:0]     px, py, pw, ph;
  logic [AWD-1:0] obj_addr;
  logic           obj_rd;
  logic           obj_en;
  logic [8:0]     ox, oy, ow, oh;
  logic           busy, done;
  logic [N-1:0]   hit_mask;
  logic           hit_any;
  logic [AWD-1:0] hit_idx;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  collide_scanner #(.N_OBJ(N), .AW(AWD), .CW(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .px(px), .py(py), .pw(pw), .ph(ph),
    .obj_addr(obj_addr), .obj_rd(obj_rd), .obj_en(obj_en),
    .ox(ox), .oy(oy), .ow(ow), .oh(oh),
    .busy(busy), .done(done),
    .hit_mask(hit_mask), .hit_any(hit_any), .hit_idx(hit_idx)
  );

  // Object table RAM with 1-cycle sync read. Outside valid-read cycles it drives
  // an enabled full-screen box so ungated sampling would create hits.
  box_t tbl [N];
  bit   en_t [N];
  logic rdv = 1'b0;
  logic [AWD-1:0] ra = '0;
  box_t cur;
  localparam box_t JUNK = '{x: 9'd0, y: 9'd0, w: 9'd511, h: 9'd511};

  always @(posedge clk) begin
    rdv <= obj_rd;
    ra  <= obj_addr;
  end
  assign cur    = rdv ? tbl[ra] : JUNK;
  assign obj_en = rdv ? en_t[ra] : 1'b1;
  assign ox = cur.x;
  assign oy = cur.y;
  assign ow = cur.w;
  assign oh = cur.h;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic box_t mk(input int x, input int y, input int w, input int h);
    box_t b;
    b.x = 9'(x); b.y = 9'(y); b.w = 9'(w); b.h = 9'(h);
    return b;
  endfunction

  // Reference: strict interval overlap in plain integers, empty boxes never hit.
  function automatic bit ov(input box_t a, input box_t b);
    int ax = int'(a.x), ay = int'(a.y), aw = int'(a.w), ah = int'(a.h);
    int bx = int'(b.x), by = int'(b.y), bw = int'(b.w), bh = int'(b.h);
    if (aw == 0 || ah == 0 || bw == 0 || bh == 0) return 1'b0;
    return (ax < bx + bw) && (ax + aw > bx) && (ay < by + bh) && (ay + ah > by);
  endfunction

  task automatic model(input box_t p, output longint m, output longint any, output longint idx);
    m = 0; any = 0; idx = 0;
    for (int i = 0; i < N; i++) begin
      if (en_t[i] && ov(p, tbl[i])) begin
        m |= longint'(1) << i;
        if (any == 0) idx = i;
        any = 1;
      end
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < N; i++) begin
      tbl[i]  = JUNK;
      en_t[i] = 1'b0;
    end
  endtask

  task automatic junk_probe();
    px = 9'($urandom); py = 9'($urandom); pw = 9'($urandom); ph = 9'($urandom);
  endtask

  // Runs one scan; lat = clock edges from the accepting edge to the done cycle.
  // noisy holds start high (with junk probe) during busy and DONE.
  task automatic do_scan(input box_t p, input bit noisy, output int lat);
    bit got = 1'b0;
    bit busy_bad = 1'b0;
    @(negedge clk);
    start = 1'b1; px = p.x; py = p.y; pw = p.w; ph = p.h;
    @(posedge clk); #1;
    start = noisy;
    junk_probe();
    chk("clear_on_start_mask", longint'(hit_mask), 0);
    chk("clear_on_start_any", longint'(hit_any), 0);
    chk("busy_after_start", longint'(busy), 1);
    lat = 0;
    while (!got && lat < N + 10) begin
      @(posedge clk); #1;
      lat++;
      if (noisy) junk_probe();
      if (done) got = 1'b1;
      else if (!busy) busy_bad = 1'b1;
    end
    chk("done_seen", longint'(got), 1);
    chk("busy_held", longint'(busy_bad), 0);
    chk("busy_low_at_done", longint'(busy), 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_not_queued", longint'(busy), 0);
    chk("done_one_cycle", longint'(done), 0);
  endtask

  typedef struct {
    string name;
    box_t  probe;
    box_t  ent;
    bit    en;
    int    slot;
    bit    exp;
  } vec_t;

  function automatic vec_t mkv(input string n, input box_t p, input box_t e,
                               input bit en, input int slot, input bit exp);
    vec_t v;
    v.name = n; v.probe = p; v.ent = e; v.en = en; v.slot = slot; v.exp = exp;
    return v;
  endfunction

  initial begin
    vec_t vecs[10];
    int   lat;
    int   n;
    bit   seen_done, seen_busy;
    longint em, ea, ei;
    box_t p;

    rst_n = 1'b0; start = 1'b0;
    px = '0; py = '0; pw = '0; ph = '0;
    clear_table();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", longint'(obj_addr), 0);
    chk("rst_rd", longint'(obj_rd), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_mask", longint'(hit_mask), 0);
    chk("rst_any", longint'(hit_any), 0);
    chk("rst_idx", longint'(hit_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: one live entry in an otherwise disabled table.
    vecs[0] = mkv("touch_x",   mk(0,0,10,10),      mk(10,0,5,5),      1, 0, 0);
    vecs[1] = mkv("overlap_x", mk(0,0,10,10),      mk(9,0,5,5),       1, 0, 1);
    vecs[2] = mkv("touch_y",   mk(0,0,10,10),      mk(0,10,5,5),      1, 0, 0);
    vecs[3] = mkv("touch_lft", mk(20,20,10,10),    mk(15,20,5,5),     1, 6, 0);
    vecs[4] = mkv("wrap_hit",  mk(500,500,20,20),  mk(505,505,10,10), 1, 2, 1);
    vecs[5] = mkv("zero_w",    mk(500,500,20,20),  mk(505,505,0,10),  1, 4, 0);
    vecs[6] = mkv("probe_h0",  mk(500,500,20,0),   mk(505,505,10,10), 1, 4, 0);
    vecs[7] = mkv("disabled",  mk(10,10,8,8),      mk(12,12,4,4),     0, 7, 0);
    vecs[8] = mkv("last_slot", mk(100,100,4,4),    mk(0,0,511,511),   1, 15, 1);
    vecs[9] = mkv("wrap_ent",  mk(505,0,5,5),      mk(500,0,20,5),    1, 1, 1);

    for (int i = 0; i < 10; i++) begin
      clear_table();
      tbl[vecs[i].slot]  = vecs[i].ent;
      en_t[vecs[i].slot] = vecs[i].en;
      do_scan(vecs[i].probe, 1'b0, lat);
      chk({vecs[i].name, "_lat"}, longint'(lat), N + 1);
      chk({vecs[i].name, "_mask"}, longint'(hit_mask), longint'(vecs[i].exp) << vecs[i].slot);
      chk({vecs[i].name, "_any"}, longint'(hit_any), longint'(vecs[i].exp));
      chk({vecs[i].name, "_idx"}, longint'(hit_idx), vecs[i].exp ? longint'(vecs[i].slot) : 0);
    end

    // Two hits, lowest index wins; start pulses during busy and DONE ignored.
    clear_table();
    tbl[3] = mk(14,14,4,4);  en_t[3] = 1'b1;
    tbl[9] = mk(0,0,50,50);  en_t[9] = 1'b1;
    do_scan(mk(10,10,8,8), 1'b1, lat);
    chk("two_hit_lat", longint'(lat), N + 1);
    chk("two_hit_mask", longint'(hit_mask), 64'h0208);
    chk("two_hit_any", longint'(hit_any), 1);
    chk("two_hit_idx", longint'(hit_idx), 3);
    repeat (3) @(posedge clk);
    #1;
    chk("results_held", longint'(hit_mask), 64'h0208);

    // Back-to-back: next scan clears the old mask and reports only the new hit.
    clear_table();
    tbl[12] = mk(0,0,20,20); en_t[12] = 1'b1;
    do_scan(mk(5,5,5,5), 1'b0, lat);
    chk("b2b_mask", longint'(hit_mask), 64'h1000);
    chk("b2b_idx", longint'(hit_idx), 12);

    // Reset mid-scan at address 5.
    @(negedge clk);
    start = 1'b1; px = 9'd5; py = 9'd5; pw = 9'd5; ph = 9'd5;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (obj_addr != 4'd5 && n < 3 * N) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_addr5", longint'(obj_addr), 5);
    rst_n = 1'b0;
    #1;
    chk("midrst_addr", longint'(obj_addr), 0);
    chk("midrst_rd", longint'(obj_rd), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_mask", longint'(hit_mask), 0);
    chk("midrst_any", longint'(hit_any), 0);
    chk("midrst_idx", longint'(hit_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0; seen_busy = 1'b0;
    repeat (N + 4) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
      if (busy) seen_busy = 1'b1;
    end
    chk("midrst_no_done", longint'(seen_done), 0);
    chk("midrst_idle", longint'(seen_busy), 0);

    // Randomized scans against the model.
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++) begin
        tbl[i].x = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(440, 511)) : 9'($urandom_range(0, 80));
        tbl[i].y = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(440, 511)) : 9'($urandom_range(0, 80));
        tbl[i].w = 9'($urandom_range(0, 40));
        tbl[i].h = 9'($urandom_range(0, 40));
        en_t[i]  = ($urandom_range(0, 3) != 0);
      end
      p.x = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(440, 511)) : 9'($urandom_range(0, 80));
      p.y = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(440, 511)) : 9'($urandom_range(0, 80));
      p.w = 9'($urandom_range(0, 60));
      p.h = 9'($urandom_range(0, 60));
      do_scan(p, t[0], lat);
      model(p, em, ea, ei);
      chk("rnd_lat", longint'(lat), N + 1);
      chk("rnd_mask", longint'(hit_mask), em);
      chk("rnd_any", longint'(hit_any), ea);
      chk("rnd_idx", longint'(hit_idx), ei);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
